// File: rtl/alu_muldiv_seq_pkg.sv
// Shared encodings for the HI/LO multiply/divide sequencer and the core ALU.
package muldiv_pkg;

  // Request operation encodings
  localparam logic OP_MULTU = 1'b0;
  localparam logic OP_DIVU  = 1'b1;

  // ALU opSel codes, shared with the core's control unit
  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0001;

  // Sequencer states
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_t;

endpackage

// File: rtl/alu_muldiv_seq_if.sv
// Request/result bundle between the control unit (master) and the sequencer (slave).
interface alu_muldiv_seq_if #(parameter int data_width = 32);

  logic                  start;
  logic                  op;
  logic [data_width-1:0] operand1;
  logic [data_width-1:0] operand2;
  logic                  busy;
  logic                  done;
  logic [data_width-1:0] hi;
  logic [data_width-1:0] lo;
  logic                  divByZero;

  modport master (
    output start, op, operand1, operand2,
    input  busy, done, hi, lo, divByZero
  );

  modport slave (
    input  start, op, operand1, operand2,
    output busy, done, hi, lo, divByZero
  );

endinterface

// File: rtl/alu_muldiv_seq_alu.sv
// Core ALU (ADD/SUB subset used by the multiply/divide sequencer).
module ALU
  import muldiv_pkg::*;
#(
  parameter int data_width = 32
) (
  input  logic [data_width-1:0] operand1,
  input  logic [data_width-1:0] operand2,
  input  logic [3:0]            opSel,
  output logic [data_width-1:0] result,
  output logic                  zero
);

  // Arithmetic result selected by opSel; unknown codes produce zero.
  always_comb begin
    case (opSel)
      ALU_ADD: result = operand1 + operand2;
      ALU_SUB: result = operand1 - operand2;
      default: result = {data_width{1'b0}};
    endcase
  end

  assign zero = (result == {data_width{1'b0}});

endmodule

// File: rtl/alu_muldiv_seq.sv
// Multi-cycle unsigned MULTU/DIVU sequencer producing HI/LO.
// Shift-add multiply / restoring divide, one bit per cycle over a private ALU.
// Optional feature macro: ALU_MULDIV_DIV_EN (divide datapath present when defined).
module alu_muldiv_seq
  import muldiv_pkg::*;
#(
  parameter int data_width = 32
) (
  input logic               clk,
  input logic               rst_n,
  alu_muldiv_seq_if.slave   bus
);

  localparam int CNT_W = $clog2(data_width) + 1;
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(data_width - 1);

  state_t                state_r;
  logic                  busy_r;
  logic                  done_r;
  logic                  dbz_r;
  logic [data_width-1:0] hi_r;
  logic [data_width-1:0] lo_r;
  logic [CNT_W-1:0]      cnt_r;
  logic                  op_r;
  logic [data_width-1:0] opnd2_r;

  logic [3:0]            alu_sel_s;
  logic [data_width-1:0] alu_a_s;
  logic [data_width-1:0] alu_res_s;
  logic                  alu_zero_unused_s;
  logic                  carry_s;
  logic [data_width-1:0] hi_next_s;
  logic [data_width-1:0] lo_next_s;
`ifdef ALU_MULDIV_DIV_EN
  logic [data_width:0]   rem_s;
`endif

  ALU #(.data_width(data_width)) u_alu (
    .operand1 (alu_a_s),
    .operand2 (opnd2_r),
    .opSel    (alu_sel_s),
    .result   (alu_res_s),
    .zero     (alu_zero_unused_s)
  );

`ifdef ALU_MULDIV_DIV_EN
  // ALU operand/op mux: divide subtracts from the left-shifted remainder.
  always_comb begin
    if (op_r == OP_DIVU) begin
      alu_sel_s = ALU_SUB;
      alu_a_s   = {hi_r[data_width-2:0], lo_r[data_width-1]};
    end else begin
      alu_sel_s = ALU_ADD;
      alu_a_s   = hi_r;
    end
  end
`else
  assign alu_sel_s = ALU_ADD;
  assign alu_a_s   = hi_r;
`endif

  // Next HI/LO for one iteration of the active operation.
  always_comb begin
    hi_next_s = hi_r;
    lo_next_s = lo_r;
    carry_s   = (alu_res_s < hi_r);
`ifdef ALU_MULDIV_DIV_EN
    rem_s     = {hi_r, lo_r[data_width-1]};
`endif
    if (op_r == OP_MULTU) begin
      if (lo_r[0]) begin
        hi_next_s = {carry_s, alu_res_s[data_width-1:1]};
        lo_next_s = {alu_res_s[0], lo_r[data_width-1:1]};
      end else begin
        hi_next_s = {1'b0, hi_r[data_width-1:1]};
        lo_next_s = {hi_r[0], lo_r[data_width-1:1]};
      end
    end else begin
`ifdef ALU_MULDIV_DIV_EN
      // 33-bit compare: the shifted-out remainder bit forces a subtract.
      if (rem_s >= {1'b0, opnd2_r}) begin
        hi_next_s = alu_res_s;
        lo_next_s = {lo_r[data_width-2:0], 1'b1};
      end else begin
        hi_next_s = rem_s[data_width-1:0];
        lo_next_s = {lo_r[data_width-2:0], 1'b0};
      end
`else
      hi_next_s = hi_r;
      lo_next_s = lo_r;
`endif
    end
  end

  // Sequencer FSM with registered status and result outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      dbz_r   <= 1'b0;
      hi_r    <= {data_width{1'b0}};
      lo_r    <= {data_width{1'b0}};
      cnt_r   <= {CNT_W{1'b0}};
      op_r    <= OP_MULTU;
      opnd2_r <= {data_width{1'b0}};
    end else begin
      case (state_r)
        ST_IDLE, ST_DONE: begin
          done_r <= 1'b0;
          if (bus.start) begin
            op_r    <= bus.op;
            opnd2_r <= bus.operand2;
            cnt_r   <= {CNT_W{1'b0}};
            dbz_r   <= 1'b0;
            if (bus.op == OP_DIVU) begin
`ifdef ALU_MULDIV_DIV_EN
              if (bus.operand2 == {data_width{1'b0}}) begin
                hi_r    <= bus.operand1;
                lo_r    <= {data_width{1'b1}};
                dbz_r   <= 1'b1;
                done_r  <= 1'b1;
                state_r <= ST_DONE;
              end else begin
                hi_r    <= {data_width{1'b0}};
                lo_r    <= bus.operand1;
                busy_r  <= 1'b1;
                state_r <= ST_RUN;
              end
`else
              // No divider: complete immediately so the requester never stalls.
              hi_r    <= {data_width{1'b0}};
              lo_r    <= {data_width{1'b0}};
              done_r  <= 1'b1;
              state_r <= ST_DONE;
`endif
            end else begin
              hi_r    <= {data_width{1'b0}};
              lo_r    <= bus.operand1;
              busy_r  <= 1'b1;
              state_r <= ST_RUN;
            end
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_RUN: begin
          hi_r  <= hi_next_s;
          lo_r  <= lo_next_s;
          cnt_r <= cnt_r + CNT_ONE;
          if (cnt_r == CNT_LAST) begin
            busy_r  <= 1'b0;
            done_r  <= 1'b1;
            state_r <= ST_DONE;
          end else begin
            state_r <= ST_RUN;
          end
        end
        default: begin
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.busy      = busy_r;
  assign bus.done      = done_r;
  assign bus.hi        = hi_r;
  assign bus.lo        = lo_r;
  assign bus.divByZero = dbz_r;

endmodule

// File: tb/tb_alu_muldiv_seq.sv
// Directed, table-driven bench for alu_muldiv_seq (both ALU_MULDIV_DIV_EN builds).
module tb_alu_muldiv_seq;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  alu_muldiv_seq_if #(.data_width(32)) bus ();

  alu_muldiv_seq #(.data_width(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
    logic        exp_dbz;
    int          lat;
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Apply one table vector and check latency, results, flags and stability.
  task automatic run_vec(input int i);
    int k;
    bit got;
    bit seen_busy;
    bit overlap;
    logic [31:0] hold_hi;
    logic [31:0] hold_lo;
    @(negedge clk);
    bus.start    = 1'b1;
    bus.op       = vecs[i].op;
    bus.operand1 = vecs[i].a;
    bus.operand2 = vecs[i].b;
    k = 0; got = 1'b0; seen_busy = 1'b0; overlap = 1'b0;
    while (!got && k < 40) begin
      @(negedge clk);
      bus.start = 1'b0;
      k++;
      if (bus.busy) seen_busy = 1'b1;
      if (bus.busy && bus.done) overlap = 1'b1;
      if (bus.done) got = 1'b1;
    end
    chk($sformatf("v%0d latency", i), 64'(k), 64'(vecs[i].lat));
    chk($sformatf("v%0d hi", i), 64'(bus.hi), 64'(vecs[i].exp_hi));
    chk($sformatf("v%0d lo", i), 64'(bus.lo), 64'(vecs[i].exp_lo));
    chk($sformatf("v%0d divByZero", i), 64'(bus.divByZero), 64'(vecs[i].exp_dbz));
    chk($sformatf("v%0d busy_seen", i), 64'(seen_busy), 64'(vecs[i].lat > 1));
    chk($sformatf("v%0d busy_done_overlap", i), 64'(overlap), 64'd0);
    hold_hi = bus.hi;
    hold_lo = bus.lo;
    repeat (2) @(negedge clk);
    chk($sformatf("v%0d done_pulse_width", i), 64'(bus.done), 64'd0);
    chk($sformatf("v%0d hold", i), {bus.hi, bus.lo}, {hold_hi, hold_lo});
  endtask

  initial begin
    int k;
    int ndone;
    int first_done;
    checks = 0;
    errors = 0;

    vecs[0] = '{1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 33};
    vecs[1] = '{1'b0, 32'h1234_5678, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 1'b0, 33};
    vecs[2] = '{1'b0, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 32'h0000_0000, 1'b0, 33};
`ifdef ALU_MULDIV_DIV_EN
    vecs[3] = '{1'b1, 32'd100,       32'd7,         32'd2,         32'd14,        1'b0, 33};
    vecs[4] = '{1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0000_0000, 1'b0, 33};
    vecs[5] = '{1'b1, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 32'hFFFF_FFFF, 1'b0, 33};
    vecs[6] = '{1'b1, 32'd5,         32'd0,         32'd5,         32'hFFFF_FFFF, 1'b1, 1};
`else
    vecs[3] = '{1'b1, 32'd100,       32'd7,         32'd0,         32'd0,         1'b0, 1};
    vecs[4] = '{1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'd0,         1'b0, 1};
    vecs[5] = '{1'b1, 32'hFFFF_FFFF, 32'h0000_0001, 32'd0,         32'd0,         1'b0, 1};
    vecs[6] = '{1'b1, 32'd5,         32'd0,         32'd0,         32'd0,         1'b0, 1};
`endif
    vecs[7] = '{1'b0, 32'd6,         32'd7,         32'd0,         32'd42,        1'b0, 33};

    bus.start    = 1'b0;
    bus.op       = 1'b0;
    bus.operand1 = 32'd0;
    bus.operand2 = 32'd0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    chk("reset_outputs", {bus.busy, bus.done, bus.divByZero, bus.hi[28:0]}, 64'd0);
    chk("reset_lo", 64'(bus.lo), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) run_vec(i);

    // Start during RUN is ignored: MULTU 3x4 with a DIVU 9/2 pulse at cycle 10.
    @(negedge clk);
    bus.start = 1'b1; bus.op = 1'b0; bus.operand1 = 32'd3; bus.operand2 = 32'd4;
    ndone = 0; first_done = 0;
    for (int c = 1; c <= 45; c++) begin
      @(negedge clk);
      if (c == 10) begin
        bus.start = 1'b1; bus.op = 1'b1; bus.operand1 = 32'd9; bus.operand2 = 32'd2;
      end else begin
        bus.start = 1'b0;
      end
      if (bus.done) begin
        ndone++;
        if (first_done == 0) first_done = c;
      end
    end
    chk("ignored_start_done_count", 64'(ndone), 64'd1);
    chk("ignored_start_latency", 64'(first_done), 64'd33);
    chk("ignored_start_result", {bus.hi, bus.lo}, {32'd0, 32'd12});

    // Back-to-back: MULTU 2x3, then MULTU 6x7 requested in the DONE cycle.
    @(negedge clk);
    bus.start = 1'b1; bus.op = 1'b0; bus.operand1 = 32'd2; bus.operand2 = 32'd3;
    k = 0;
    do begin
      @(negedge clk);
      bus.start = 1'b0;
      k++;
    end while (!bus.done && k < 40);
    chk("b2b_first_latency", 64'(k), 64'd33);
    chk("b2b_first_lo", 64'(bus.lo), 64'd6);
    bus.start = 1'b1; bus.op = 1'b0; bus.operand1 = 32'd6; bus.operand2 = 32'd7;
    @(negedge clk);
    bus.start = 1'b0;
    chk("b2b_accepted_busy", {63'd0, bus.busy}, 64'd1);
    k = 1;
    while (!bus.done && k < 40) begin
      @(negedge clk);
      k++;
    end
    chk("b2b_second_latency", 64'(k), 64'd33);
    chk("b2b_second_result", {bus.hi, bus.lo}, {32'd0, 32'd42});

    // Reset mid-RUN aborts at once with no done afterwards.
    @(negedge clk);
    bus.start = 1'b1; bus.op = 1'b0; bus.operand1 = 32'hFFFF_FFFF; bus.operand2 = 32'hFFFF_FFFF;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (9) @(negedge clk);
    chk("midrun_busy_before_reset", {63'd0, bus.busy}, 64'd1);
    rst_n = 1'b0;
    #1;
    chk("midrun_reset_flags", {61'd0, bus.busy, bus.done, bus.divByZero}, 64'd0);
    chk("midrun_reset_hilo", {bus.hi, bus.lo}, 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    ndone = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (bus.done || bus.busy) ndone++;
    end
    chk("midrun_no_done_after_reset", 64'(ndone), 64'd0);

    // Recovery after reset.
    run_vec(7);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
